video_fetch_fifo: RTL and testbench

Upstream feeder for the 640x480 VGA/HDMI scanout stage. Fetches one 32-bit word per 8-pixel group from main memory over the CPU-side word-read bus and buffers the words in a small first-word-fall-through FIFO. It presents the head word as the four bitplane bytes (red, green, blue, bright) that the scanout stage consumes. Runs entirely in the CPU clock domain. The scanout stage's `rd` pulse pops the FIFO, and its active-low vsync restarts the frame.

---
 rtl/video_fetch_fifo.sv | 140 ++++++++++++++
 tb/tb_video_fetch_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetch_fifo.sv
// Frame-buffer word fetcher for the scanout stage: reads one 32-bit word per
// 8-pixel group and buffers it in a first-word-fall-through FIFO.
module video_fetch_fifo #(
    parameter int C_addr_bits   = 30,
    parameter int C_depth_log2  = 4,
    parameter int C_frame_words = 38400
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [C_addr_bits-1:0] base_addr,
    output logic                   addr_strobe,
    output logic [C_addr_bits-1:0] addr,
    input  logic                   data_ready,
    input  logic [31:0]            data_in,
    input  logic                   rd,
    input  logic                   vga_vsync,
    output logic [7:0]             red_byte,
    output logic [7:0]             green_byte,
    output logic [7:0]             blue_byte,
    output logic [7:0]             bright_byte,
    output logic                   underrun
);

    localparam int DEPTH = 1 << C_depth_log2;
    localparam int FW    = (C_frame_words >= 65536) ? 32 : 16;
    localparam logic [FW-1:0] FRAME_WORDS = FW'(C_frame_words);
    localparam logic [FW-1:0] FRAME_LAST  = FW'(C_frame_words - 1);

    typedef enum logic [1:0] {WAIT_VSYNC, FILL, REQ, DONE} state_t;

    state_t                  state;
    logic                    vs_meta, vs_sync, vs_prev;
    logic                    flush;
    logic [31:0]             mem [DEPTH];
    logic [C_depth_log2-1:0] wr_ptr, rd_ptr;
    logic [C_depth_log2:0]   count;
    logic [FW-1:0]           fetched;
    logic                    discard;
    logic [C_addr_bits-1:0]  next_base;
    logic                    do_write, do_read;
    logic [31:0]             head;

    // Synchronizer idles high so that leaving reset never looks like a vsync edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            vs_meta <= vga_vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign flush    = vs_prev & ~vs_sync;
    assign do_write = (state == REQ) && data_ready && !discard && !flush;
    assign do_read  = rd && (count != '0) && !flush;

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= data_in;
    end

    assign head        = (count != '0) ? mem[rd_ptr] : 32'h0;
    assign red_byte    = head[7:0];
    assign green_byte  = head[15:8];
    assign blue_byte   = head[23:16];
    assign bright_byte = head[31:24];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_VSYNC;
            addr_strobe <= 1'b0;
            addr        <= '0;
            underrun    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fetched     <= '0;
            discard     <= 1'b0;
            next_base   <= '0;
        end else begin
            underrun <= rd && (count == '0) && !flush;

            if (do_write)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_read)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_write && !do_read)
                count <= count + 1'b1;
            else if (!do_write && do_read)
                count <= count - 1'b1;

            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                fetched <= '0;
                // An in-flight bus read cannot be aborted; drop its data when it lands.
                if (state == REQ && !data_ready) begin
                    discard   <= 1'b1;
                    next_base <= base_addr;
                end else begin
                    discard     <= 1'b0;
                    addr        <= base_addr;
                    addr_strobe <= 1'b0;
                    state       <= FILL;
                end
            end else begin
                case (state)
                    WAIT_VSYNC: ;
                    FILL: begin
                        if (!count[C_depth_log2] && fetched < FRAME_WORDS) begin
                            addr_strobe <= 1'b1;
                            state       <= REQ;
                        end
                    end
                    REQ: begin
                        if (data_ready) begin
                            addr_strobe <= 1'b0;
                            if (discard) begin
                                discard <= 1'b0;
                                addr    <= next_base;
                                state   <= FILL;
                            end else begin
                                addr    <= addr + 1'b1;
                                fetched <= fetched + 1'b1;
                                state   <= (fetched == FRAME_LAST) ? DONE : FILL;
                            end
                        end
                    end
                    DONE: ;
                    default: state <= WAIT_VSYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_fetch_fifo.sv
// Scoreboard bench for video_fetch_fifo: a behavioural memory pushes expected
// words as it answers requests; scanout pops compare the FIFO head against them.
module tb_video_fetch_fifo;

    logic        clk;
    logic        rst_n;
    logic [29:0] base_addr;
    logic        addr_strobe;
    logic [29:0] addr;
    logic        data_ready;
    logic [31:0] data_in;
    logic        rd;
    logic        vga_vsync;
    logic [7:0]  red_byte, green_byte, blue_byte, bright_byte;
    logic        underrun;

    int          total_checks = 0;
    int          bad_checks   = 0;
    int          req_count    = 0;
    int          strobe_cycles = 0;
    int          mem_lat      = 0;
    int          wait_cnt     = 0;
    logic [29:0] exp_next     = '0;
    logic [29:0] pending_base = '0;
    bit          discard_pending = 0;
    logic [31:0] exp_q [$];

    video_fetch_fifo #(
        .C_addr_bits  (30),
        .C_depth_log2 (4),
        .C_frame_words(20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .base_addr  (base_addr),
        .addr_strobe(addr_strobe),
        .addr       (addr),
        .data_ready (data_ready),
        .data_in    (data_in),
        .rd         (rd),
        .vga_vsync  (vga_vsync),
        .red_byte   (red_byte),
        .green_byte (green_byte),
        .blue_byte  (blue_byte),
        .bright_byte(bright_byte),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wordOf(input logic [29:0] a);
        return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [31:0] headWord();
        return {bright_byte, blue_byte, green_byte, red_byte};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [29:0] base);
        base_addr = base;
        vga_vsync = 1'b0;
        tick(1);
        vga_vsync = 1'b1;
    endtask

    task automatic popHead();
        if (exp_q.size() == 0)
            checkOutput("pop_queue_empty", 32'd0, 32'd1);
        else
            checkOutput("pop_head", headWord(), exp_q.pop_front());
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    // Memory model: answers a strobe after mem_lat idle cycles with the word for that address.
    always @(negedge clk) begin
        if (rst_n && addr_strobe)
            strobe_cycles++;
        if (data_ready) begin
            data_ready = 1'b0;
            wait_cnt   = 0;
        end else if (rst_n && addr_strobe) begin
            if (wait_cnt >= mem_lat) begin
                data_ready = 1'b1;
                data_in    = wordOf(addr);
                req_count++;
                checkOutput("req_addr", {2'b00, addr}, {2'b00, exp_next});
                if (discard_pending) begin
                    discard_pending = 0;
                    exp_next        = pending_base;
                end else begin
                    exp_q.push_back(wordOf(exp_next));
                    exp_next = exp_next + 30'd1;
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  r0;
        int  s0;
        bit  seen;

        rst_n      = 1'b0;
        base_addr  = '0;
        data_ready = 1'b0;
        data_in    = '0;
        rd         = 1'b0;
        vga_vsync  = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        checkOutput("rst_strobe", {31'd0, addr_strobe}, 32'd0);
        checkOutput("rst_addr", {2'b00, addr}, 32'd0);
        checkOutput("rst_underrun", {31'd0, underrun}, 32'd0);
        checkOutput("rst_head", headWord(), 32'd0);

        tick(1000);
        checkOutput("idle_strobe_cycles", strobe_cycles, 32'd0);
        checkOutput("idle_head", headWord(), 32'd0);

        exp_q.delete();
        exp_next = 30'h1000;
        applyStimulus(30'h1000);
        tick(200);
        checkOutput("fill_req_count", req_count, 32'd16);
        checkOutput("fill_strobe_low", {31'd0, addr_strobe}, 32'd0);
        checkOutput("fill_queue_size", exp_q.size(), 32'd16);
        checkOutput("fill_head", headWord(), wordOf(30'h1000));

        for (int i = 0; i < 20; i++) begin
            popHead();
            tick(6);
            checkOutput("refill_count", req_count, 32'(16 + ((i < 4) ? i + 1 : 4)));
        end
        checkOutput("drain_head", headWord(), 32'd0);
        checkOutput("drain_queue", exp_q.size(), 32'd0);
        s0 = strobe_cycles;
        tick(50);
        checkOutput("done_no_strobe", strobe_cycles, s0);
        checkOutput("done_req_count", req_count, 32'd20);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        checkOutput("underrun_pulse", {31'd0, underrun}, 32'd1);
        checkOutput("underrun_head", headWord(), 32'd0);
        tick(1);
        checkOutput("underrun_clear", {31'd0, underrun}, 32'd0);

        mem_lat = 5;
        exp_q.delete();
        exp_next = 30'h1000;
        r0 = req_count;
        applyStimulus(30'h1000);
        seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            if (addr_strobe && addr == 30'h1005) seen = 1;
            else tick(1);
        end
        if (!seen) checkOutput("timeout_req_1005", 32'd0, 32'd1);
        pending_base    = 30'h2000;
        discard_pending = 1;
        exp_q.delete();
        applyStimulus(30'h2000);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            checkOutput("held_strobe", {31'd0, addr_strobe}, 32'd1);
            checkOutput("held_addr", {2'b00, addr}, 32'h1005);
            if (data_ready) seen = 1;
            else tick(1);
        end
        if (!seen) checkOutput("timeout_discard_ready", 32'd0, 32'd1);
        tick(300);
        checkOutput("discard_req_count", req_count - r0, 32'd22);
        checkOutput("discard_queue_size", exp_q.size(), 32'd16);
        checkOutput("discard_head", headWord(), wordOf(30'h2000));

        mem_lat = 10;
        exp_q.delete();
        exp_next = 30'h3000;
        r0 = req_count;
        applyStimulus(30'h3000);
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (data_ready && req_count == r0 + 2) seen = 1;
            else tick(1);
        end
        if (!seen) checkOutput("timeout_second_word", 32'd0, 32'd1);
        popHead();
        checkOutput("simul_head", headWord(), wordOf(30'h3001));
        popHead();
        checkOutput("simul_empty_head", headWord(), 32'd0);
        checkOutput("simul_no_underrun", {31'd0, underrun}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
